// File: rtl/rf_trace_pkg.sv
// rf_trace_pkg: states, beat tags and beat indices shared by the trace sequencer.
// TRACE_FRAME_CNT_EN makes the frame-count beat the first beat of each frame.
package rf_trace_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;
    localparam int BCNT_W = 6;
    localparam int DROP_W = 16;
    localparam int FCNT_W = 32;
    localparam logic [5:0] TAG_PC   = 6'h20;
    localparam logic [5:0] TAG_INST = 6'h21;
    localparam logic [5:0] TAG_FCNT = 6'h22;
    localparam logic [BCNT_W-1:0] BEAT_FCNT = 6'd0;
    localparam logic [BCNT_W-1:0] BEAT_PC   = 6'd1;
    localparam logic [BCNT_W-1:0] BEAT_INST = 6'd2;
    localparam logic [BCNT_W-1:0] BEAT_REG0 = 6'd3;
`ifdef TRACE_FRAME_CNT_EN
    localparam logic [BCNT_W-1:0] BEAT_FIRST = BEAT_FCNT;
`else
    localparam logic [BCNT_W-1:0] BEAT_FIRST = BEAT_PC;
`endif
    function automatic logic [5:0] beat_tag(input logic [BCNT_W-1:0] idx);
        return idx == BEAT_FCNT ? TAG_FCNT :
               idx == BEAT_PC   ? TAG_PC   :
               idx == BEAT_INST ? TAG_INST : idx - BEAT_REG0;
    endfunction
endpackage

// File: rtl/rf_trace_ctrl_if.sv
// rf_trace_ctrl_if: valid/ready trace beat port of the trace sequencer.
interface rf_trace_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              trc_valid;
    logic              trc_ready;
    logic [DATA_W-1:0] trc_data;
    logic [TAG_W-1:0]  trc_tag;
    logic              trc_last;
    modport master(output trc_valid, trc_data, trc_tag, trc_last, input trc_ready);
    modport slave(input trc_valid, trc_data, trc_tag, trc_last, output trc_ready);
endinterface

// File: rtl/trc_out_reg.sv
// trc_out_reg: single-entry valid/ready holding register, loads when empty or when its beat is accepted.
module trc_out_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);
    logic         valid_q;
    logic [W-1:0] data_q;
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) data_q <= in_data_i;
        end
    end
endmodule

// File: rtl/rf_trace_ctrl.sv
// rf_trace_ctrl: freezes the CPU after each traced retire and streams PC, instruction and all registers.
// Build with TRACE_FRAME_CNT_EN to prepend a 32-bit frame-count beat to every frame.
module rf_trace_ctrl
    import rf_trace_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 trace_en,
    input  logic                 retire,
    input  logic [DATA_W-1:0]    retire_pc,
    input  logic [DATA_W-1:0]    retire_inst,
    output logic                 cpu_stall,
    output logic [4:0]           dbg_raddr,
    input  logic [DATA_W-1:0]    dbg_rdata,
    rf_trace_ctrl_if.master      trc,
    output logic [DROP_W-1:0]    drop_cnt
);
    localparam logic [BCNT_W-1:0] BEAT_LAST = BEAT_REG0 + BCNT_W'(NUM_REGS - 1);
    localparam int PW = 1 + TAG_W + DATA_W;
    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d, idx;
    logic [DATA_W-1:0]   pc_q, inst_q, beat_data, fcnt_data;
    logic [DROP_W-1:0]   drop_q;
    logic                ld_valid, ld_ready, hs, done, start;
    logic [PW-1:0]       ld_payload, out_payload;
`ifdef TRACE_FRAME_CNT_EN
    logic [FCNT_W-1:0]   fcnt_q;
    always_ff @(posedge clk_in) begin
        if (reset) fcnt_q <= '0;
        else if (done) fcnt_q <= fcnt_q + 1'b1;
    end
    assign fcnt_data = DATA_W'(fcnt_q);
`else
    assign fcnt_data = '0;
`endif
    assign hs        = trc.trc_valid && trc.trc_ready;
    assign done      = hs && trc.trc_last;
    assign start     = state_q == IDLE && retire && trace_en;
    assign cpu_stall = state_q != IDLE;
    assign drop_cnt  = drop_q;
    // idx is the beat being loaded this cycle; register beats read the regfile through it directly
    assign idx       = state_q == LOAD ? BEAT_FIRST : cnt_q;
    assign dbg_raddr = idx >= BEAT_REG0 ? 5'(idx - BEAT_REG0) : 5'd0;
    assign beat_data = idx == BEAT_FCNT ? fcnt_data :
                       idx == BEAT_PC   ? pc_q      :
                       idx == BEAT_INST ? inst_q    : dbg_rdata;
    assign ld_payload = {idx == BEAT_LAST, TAG_W'(beat_tag(idx)), beat_data};
    assign ld_valid   = state_q == LOAD || (state_q == SEND && !trc.trc_last);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: begin
                state_d = SEND;
                cnt_d   = BEAT_FIRST + 1'b1;
            end
            SEND: begin
                state_d = done ? IDLE : SEND;
                cnt_d   = done ? '0 : hs ? cnt_q + 1'b1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                pc_q   <= retire_pc;
                inst_q <= retire_inst;
            end
            if (retire && state_q != IDLE && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end
    trc_out_reg #(.W(PW)) u_out (
        .clk_i      (clk_in),
        .rst_i      (reset),
        .in_valid_i (ld_valid),
        .in_data_i  (ld_payload),
        .in_ready_o (ld_ready),
        .out_valid_o(trc.trc_valid),
        .out_data_o (out_payload),
        .out_ready_i(trc.trc_ready)
    );
    assign {trc.trc_last, trc.trc_tag, trc.trc_data} = out_payload;
endmodule

// File: doc/rf_trace_ctrl.md
Name: rf_trace_ctrl

Overview:
Hardware trace sequencer for the single-cycle CPU. After each retired instruction it freezes the core and streams one frame out over a valid/ready trace port: PC, instruction word, then every architectural register. Registers are read through the regfile's debug read port. Sits beside sccpu inside sccomp_dataflow. Produces on silicon the same per-instruction dump the pre-simulation bench writes to file.

Parameters:
NUM_REGS, 32, number of architectural registers dumped per frame (power of two, ≤32)
DATA_W, 32, width of PC, instruction and register data
TAG_W, 6, width of beat tag

Ports:
clk_in  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
trace_en  in  1  frames generated only while high; sampled at retire
retire  in  1  one-cycle pulse: an instruction commits at this rising edge
retire_pc  in  DATA_W  PC of the committing instruction
retire_inst  in  DATA_W  instruction word of the committing instruction
cpu_stall  out  1  clock-enable gate to the CPU (PC, regfile, DMEM writes)
dbg_raddr  out  5  regfile debug read address
dbg_rdata  in  DATA_W  regfile debug read data, combinational from dbg_raddr
trc_valid  out  1  trace beat valid
trc_ready  in  1  downstream accepts beat
trc_data  out  DATA_W  beat payload
trc_tag  out  TAG_W  0x00–0x1F = register n; 0x20 = PC; 0x21 = instruction; 0x22 = frame count
trc_last  out  1  marks the final beat of a frame
drop_cnt  out  16  retire pulses ignored while busy; saturates at 0xFFFF

Behaviour:
- Reset (synchronous, any state): state=IDLE; cpu_stall=0, trc_valid=0, trc_data=0, trc_tag=0, trc_last=0, dbg_raddr=0, drop_cnt=0, beat counter=0. Any partial frame is discarded with no trailing beat.
- States: IDLE, LOAD, SEND.
- IDLE:
  - cpu_stall=0, trc_valid=0.
  - On retire&trace_en: latch retire_pc and retire_inst; go to LOAD. The CPU has already committed at this edge.
  - retire with trace_en=0 is ignored.
- LOAD:
  - cpu_stall=1.
  - Loads the first beat into the output register at the edge: trc_valid=1, PC beat.
  - Go to SEND.
  - First beat is visible 2 cycles after the retire edge. cpu_stall is asserted from the cycle after the retire edge.
- SEND:
  - cpu_stall=1.
  - Output register holds the beat while trc_valid&!trc_ready. data, tag and last stay stable; valid never drops without a handshake.
  - On handshake, the next beat is loaded the same edge, giving 1 beat/cycle with ready held high.
  - Beat order: PC(0x20), INST(0x21), R0..R(NUM_REGS-1).
  - Register beats: dbg_raddr = index of the beat being loaded, driven combinationally from the counter. dbg_rdata is captured at the loading edge.
  - Handshake on the trc_last beat: trc_valid=0 and state→IDLE at that edge. cpu_stall deasserts the following cycle.
- Frame length: NUM_REGS+2 beats (34 by default). Minimum stall is NUM_REGS+3 cycles.
- retire asserted in LOAD/SEND is a protocol violation: ignored and drop_cnt++ (saturating).
- trace_en falling mid-frame has no effect; the frame completes.
- trc_ready is ignored while trc_valid=0.
- Counter widths: beat counter 6 bits, no wrap within a frame.

Optional Feature:
- Macro TRACE_FRAME_CNT_EN.
- Defined:
  - 32-bit frame counter, reset to 0, incremented on each completed frame (wraps 0xFFFFFFFF→0).
  - Emitted as an extra first beat, tag 0x22, before PC.
  - Frame is NUM_REGS+3 beats.
- Undefined: no counter, no 0x22 beat; tag 0x22 never appears.

Decomposition:
- Package rf_trace_pkg:
  - state enum (IDLE/LOAD/SEND)
  - tag constants TAG_PC=0x20, TAG_INST=0x21, TAG_FCNT=0x22
  - beat-index constants
  - DROP_W=16
- One sub-module, trc_out_reg: a single-entry valid/ready holding register, load-on-accept-or-empty, reused for the output stage.

Test Plan:
- Reset, then retire pc=0x00400000 inst=0x3c010000 with regs Rn=n, trc_ready=1 → cpu_stall high next cycle; 34 consecutive beats: (0x20,0x00400000), (0x21,0x3c010000), (0x00,0), (0x01,1)…(0x1F,0x1F); trc_last only on R31; cpu_stall low the cycle after.
- Same frame with trc_ready toggling 1,0,0,1 repeatedly → identical beat sequence; data/tag stable while stalled; no beat duplicated or skipped.
- Extra retire pulse mid-frame → frame unchanged; drop_cnt=1. Force 0x10000 violations → drop_cnt holds 0xFFFF.
- reset asserted on beat 10 → next cycle trc_valid=0, cpu_stall=0; a new retire yields a full fresh frame starting with the PC beat.
- trace_en=0 with retire → no beats and cpu_stall stays 0. trace_en dropping mid-frame → frame still completes.
- TRACE_FRAME_CNT_EN defined, three back-to-back frames → first beats (0x22,0),(0x22,1),(0x22,2); 35 beats each. Undefined → tag 0x22 never seen.
